// File: rtl/four_bit_synchronous_down_counter.sv
// Four-bit cascadable down counter with parallel load, a reload register for
// auto-reload on underflow, combinational zero/borrow and a registered done pulse.
module four_bit_synchronous_down_counter #(
    parameter logic [3:0] RELOAD_INIT = 4'hF
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       cnt_en,
    input  logic       load,
    input  logic [3:0] d,
    input  logic       reload_en,
    output logic [3:0] q,
    output logic       borrow_out,
    output logic       zero,
    output logic       done
);

    logic [3:0] count_q, count_d;
    logic [3:0] rld_q, rld_d;
    logic       done_q, done_d;
    logic       at_zero;
    logic       underflow;

    assign at_zero   = (count_q == 4'h0);
    // Load wins over counting, so a load at zero is never an underflow.
    assign underflow = !load && cnt_en && at_zero;

    always_comb begin
        count_d = count_q;
        rld_d   = rld_q;
        done_d  = underflow;
        if (load) begin
            count_d = d;
            rld_d   = d;
        end else if (cnt_en) begin
            if (at_zero) begin
                count_d = reload_en ? rld_q : 4'hF;
            end else begin
                count_d = count_q - 4'h1;
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count_q <= 4'h0;
            rld_q   <= RELOAD_INIT;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            rld_q   <= rld_d;
            done_q  <= done_d;
        end
    end

    // Borrow is unregistered so a chain of stages shares one clock edge.
    assign q          = count_q;
    assign zero       = at_zero;
    assign borrow_out = cnt_en & at_zero;
    assign done       = done_q;

endmodule

// File: tb/tb_four_bit_synchronous_down_counter.sv
// Bench for four_bit_synchronous_down_counter: directed vector table, async-clear
// sequences, randomized run against an arithmetic model, and a two-stage cascade.
module tb_four_bit_synchronous_down_counter;

    localparam logic [3:0] RINIT = 4'hA;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       cnt_en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] d = 4'h0;
    logic       reload_en = 1'b0;
    logic [3:0] q;
    logic       borrow_out, zero, done;

    logic       c_clear = 1'b0;
    logic       c_en = 1'b0;
    logic [3:0] lo_q, hi_q;
    logic       lo_borrow, lo_zero, lo_done, hi_borrow, hi_zero, hi_done;

    int n_checks = 0;
    int n_pass = 0;

    // Reference state: plain integers following the counting rules.
    int m_q = 0;
    int m_rld = RINIT;
    int m_done = 0;

    typedef struct {
        bit         ld;
        bit         en;
        bit         rel;
        logic [3:0] dv;
        logic [3:0] exp_q;
        bit         exp_done;
    } vec_t;

    vec_t vecs[$];

    four_bit_synchronous_down_counter #(.RELOAD_INIT(RINIT)) dut (
        .clock(clock), .clear(clear), .cnt_en(cnt_en), .load(load), .d(d),
        .reload_en(reload_en), .q(q), .borrow_out(borrow_out), .zero(zero), .done(done)
    );

    four_bit_synchronous_down_counter u_lo (
        .clock(clock), .clear(c_clear), .cnt_en(c_en), .load(1'b0), .d(4'h0),
        .reload_en(1'b0), .q(lo_q), .borrow_out(lo_borrow), .zero(lo_zero), .done(lo_done)
    );

    four_bit_synchronous_down_counter u_hi (
        .clock(clock), .clear(c_clear), .cnt_en(lo_borrow), .load(1'b0), .d(4'h0),
        .reload_en(1'b0), .q(hi_q), .borrow_out(hi_borrow), .zero(hi_zero), .done(hi_done)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step(input bit l, input bit c, input bit r, input logic [3:0] dv);
        if (l) begin
            m_q = dv; m_rld = dv; m_done = 0;
        end else if (c) begin
            m_done = (m_q == 0);
            if (m_q == 0 && r) m_q = m_rld;
            else m_q = (m_q + 15) % 16;
        end else begin
            m_done = 0;
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_rld = RINIT; m_done = 0;
    endtask

    // Drive one cycle of inputs, check combinational outputs, take an edge, check q/done.
    task automatic apply(input bit l, input bit c, input bit r, input logic [3:0] dv);
        load = l; cnt_en = c; reload_en = r; d = dv;
        #1;
        check("zero_comb", 8'(zero), 8'(m_q == 0));
        check("borrow_comb", 8'(borrow_out), 8'(c && m_q == 0));
        @(posedge clock);
        model_step(l, c, r, dv);
        #1;
        check("q_model", 8'(q), 8'(m_q));
        check("done_model", 8'(done), 8'(m_done));
    endtask

    task automatic add(input bit l, input bit c, input bit r, input logic [3:0] dv,
                       input logic [3:0] eq, input bit ed);
        vec_t v;
        v.ld = l; v.en = c; v.rel = r; v.dv = dv; v.exp_q = eq; v.exp_done = ed;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] prev_q;

        // Free wrap from reset: 0, F, E, ..., 0, F with done after edges 1 and 17.
        for (int k = 1; k <= 17; k++) add(0, 1, 0, 4'h0, 4'((16 - k) % 16), (k == 1 || k == 17));
        add(1, 0, 0, 4'h5, 4'h5, 0);
        add(0, 1, 1, 4'h0, 4'h4, 0);
        add(0, 1, 1, 4'h0, 4'h3, 0);
        add(0, 1, 1, 4'h0, 4'h2, 0);
        add(0, 1, 1, 4'h0, 4'h1, 0);
        add(0, 1, 1, 4'h0, 4'h0, 0);
        add(0, 1, 1, 4'h0, 4'h5, 1);
        add(0, 1, 1, 4'h0, 4'h4, 0);
        for (int k = 1; k <= 4; k++) add(0, 1, 1, 4'h0, 4'(4 - k), 0);
        // Load at zero with cnt_en high: load wins, no done.
        add(1, 1, 1, 4'h9, 4'h9, 0);
        // Prove rld captured 9 by counting through an auto-reload.
        for (int k = 1; k <= 9; k++) add(0, 1, 1, 4'h0, 4'(9 - k), 0);
        add(0, 1, 1, 4'h0, 4'h9, 1);
        add(0, 0, 1, 4'h3, 4'h9, 0);
        add(0, 0, 0, 4'h3, 4'h9, 0);
        // Degenerate reload value of zero.
        add(1, 0, 1, 4'h0, 4'h0, 0);
        for (int k = 1; k <= 4; k++) add(0, 1, 1, 4'h0, 4'h0, 1);
        add(0, 0, 1, 4'h0, 4'h0, 0);

        // Reset state, with inputs toggling and clock edges while clear is low.
        load = 1'b1; d = 4'h7; cnt_en = 1'b1; reload_en = 1'b1;
        #1;
        check("rst_q", 8'(q), 8'h0);
        check("rst_done", 8'(done), 8'h0);
        check("rst_zero", 8'(zero), 8'h1);
        check("rst_borrow_en", 8'(borrow_out), 8'h1);
        cnt_en = 1'b0;
        #1;
        check("rst_borrow_dis", 8'(borrow_out), 8'h0);
        @(posedge clock); @(posedge clock); #1;
        check("rst_ignores_edges", 8'(q), 8'h0);
        @(negedge clock);
        load = 1'b0; cnt_en = 1'b0; reload_en = 1'b0; d = 4'h0;
        clear = 1'b1;
        model_reset();
        @(posedge clock); #1;

        prev_q = 4'h0;
        foreach (vecs[i]) begin
            load = vecs[i].ld; cnt_en = vecs[i].en; reload_en = vecs[i].rel; d = vecs[i].dv;
            #1;
            check("vec_zero", 8'(zero), 8'(prev_q == 4'h0));
            check("vec_borrow", 8'(borrow_out), 8'(vecs[i].en && prev_q == 4'h0));
            @(posedge clock);
            model_step(vecs[i].ld, vecs[i].en, vecs[i].rel, vecs[i].dv);
            #1;
            check("vec_q", 8'(q), 8'(vecs[i].exp_q));
            check("vec_done", 8'(done), 8'(vecs[i].exp_done));
            prev_q = vecs[i].exp_q;
        end

        // Async clear mid-run at q = 6.
        apply(1, 0, 1, 4'h8);
        apply(0, 1, 1, 4'h0);
        apply(0, 1, 1, 4'h0);
        check("pre_clear_q6", 8'(q), 8'h6);
        #2 clear = 1'b0;
        #1;
        check("aclr_q", 8'(q), 8'h0);
        check("aclr_done", 8'(done), 8'h0);
        check("aclr_zero", 8'(zero), 8'h1);
        model_reset();
        @(negedge clock);
        clear = 1'b1;
        #1;
        check("no_done_from_reset", 8'(done), 8'h0);
        apply(0, 1, 1, 4'h0);
        check("reload_is_init", 8'(q), 8'(RINIT));

        // Clear while done is high must drop done immediately.
        apply(1, 0, 0, 4'h0);
        apply(0, 1, 0, 4'h0);
        check("done_before_clear", 8'(done), 8'h1);
        #2 clear = 1'b0;
        #1;
        check("aclr_done_hi", 8'(done), 8'h0);
        model_reset();
        @(negedge clock);
        clear = 1'b1;

        // Randomized run with occasional asynchronous clears.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                #2 clear = 1'b0;
                #1;
                check("rnd_aclr_q", 8'(q), 8'h0);
                check("rnd_aclr_done", 8'(done), 8'h0);
                model_reset();
                @(negedge clock);
                clear = 1'b1;
            end
            apply($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        // Two-stage cascade counts as one 8-bit down counter.
        @(negedge clock);
        c_clear = 1'b1;
        #1;
        check("casc_init", {hi_q, lo_q}, 8'h00);
        c_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            check("casc_pair", {hi_q, lo_q}, 8'((256 - k) % 256));
        end
        c_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/four_bit_synchronous_down_counter.md
FOUR_BIT_SYNCHRONOUS_DOWN_COUNTER -- requirements
Module: four_bit_synchronous_down_counter

Interface
REQ-001 Parameter: RELOAD_INIT, default 4'hF, meaning reset value of the internal reload register.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-low.
REQ-004 cnt_en  input  1  count enable; decrement by one when high.
REQ-005 load  input  1  synchronous parallel load strobe.
REQ-006 d  input  4  parallel load value; also captured as reload value.
REQ-007 reload_en  input  1  1 = auto-reload at underflow, 0 = free-running wrap.
REQ-008 q  output  4  current count, registered.
REQ-009 borrow_out  output  1  cascade borrow to next stage, combinational.
REQ-010 zero  output  1  high while q == 0, combinational from q.
REQ-011 done  output  1  one-cycle registered pulse after an underflow event.

Function
REQ-012 The block SHALL hold a 4-bit count register q and a 4-bit reload register rld.
REQ-013 Per rising edge, priority SHALL be: load, then cnt_en, then hold.
REQ-014 load = 1: q <= d and rld <= d in the same edge, regardless of cnt_en.
REQ-015 load = 0, cnt_en = 1, q != 0: q <= q - 1, modulo 16.
REQ-016 load = 0, cnt_en = 1, q == 0, reload_en = 1: q <= rld (underflow with reload).
REQ-017 load = 0, cnt_en = 1, q == 0, reload_en = 0: q <= 4'hF (underflow with wrap).
REQ-018 load = 0, cnt_en = 0: q and rld SHALL hold.
REQ-019 rld SHALL change only on load or clear.
REQ-020 borrow_out SHALL equal cnt_en & (q == 0), with no register stage.
- Permits cascading stages: borrow_out of stage n drives cnt_en of stage n+1, all on a common clock.
REQ-021 zero SHALL equal (q == 0) combinationally, independent of cnt_en.
REQ-022 An underflow event is one edge with load = 0, cnt_en = 1 and q == 0.
REQ-023 done SHALL be 1 for exactly the one cycle following each underflow event, and 0 otherwise.
REQ-024 Consecutive underflow events SHALL keep done high for consecutive cycles.
- Example: rld = 0, reload_en = 1, cnt_en held high.
REQ-025 load coincident with q == 0 and cnt_en = 1 SHALL NOT count as underflow; done = 0 next cycle.
REQ-026 rld = 0 with reload_en = 1 SHALL keep q at 0 and underflow on every enabled edge.
REQ-027 Latency: q reflects load or decrement one edge after the qualifying inputs; borrow_out and zero follow q with zero cycles of delay.

Reset
REQ-028 clear = 0 SHALL immediately, without a clock, force q = 4'h0, rld = RELOAD_INIT and done = 0.
REQ-029 While clear = 0, all inputs SHALL be ignored; zero = 1 and borrow_out = cnt_en.
REQ-030 Reset asserted mid-count SHALL abort the count; no done pulse is produced by the reset.
REQ-031 On the first rising edge after clear deasserts, the block SHALL operate normally from q = 0.

Verification
REQ-032 Reset then free count: clear pulse, reload_en = 0, cnt_en = 1 for 17 edges.
- Required q sequence: 0, F, E, ..., 1, 0, F.
- done high after edges 1 and 17.
REQ-033 Load and auto-reload: load d = 5, then cnt_en = 1, reload_en = 1.
- Required q sequence: 5, 4, 3, 2, 1, 0, 5, 4.
- done high the cycle q returns to 5.
REQ-034 Load priority: q = 0, cnt_en = 1, load = 1, d = 9 on the same edge.
- Required: q = 9, done = 0, rld = 9.
REQ-035 Cascade: two instances, low stage borrow_out driving high stage cnt_en, both cleared, low cnt_en = 1.
- Required: 8-bit pair counts 00, FF, FE, ...
- High stage decrements only on low-stage underflow edges.
REQ-036 Async clear mid-run: at q = 6, assert clear between clock edges.
- Required: q = 0 and done = 0 immediately, with no clock edge.
- rld = RELOAD_INIT; zero = 1.
REQ-037 Degenerate reload: load d = 0, reload_en = 1, cnt_en = 1 for 4 edges.
- Required: q stays 0; done = 1 for 4 consecutive cycles; borrow_out = 1 throughout.
